// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection phase scheduler.
package traffic_pkg;

    // Output phase codes. ALL_RED only follows reset and reports 3'b111, the
    // same code as NS_LT_Y; the two are told apart by the lamps (NS_LT_Y has ns_y).
    typedef enum logic [2:0] {
        PH_NS_GREEN  = 3'd0,
        PH_NS_YELLOW = 3'd1,
        PH_EW_LT     = 3'd2,
        PH_EW_LT_Y   = 3'd3,
        PH_EW_GREEN  = 3'd4,
        PH_EW_YELLOW = 3'd5,
        PH_NS_LT     = 3'd6,
        PH_NS_LT_Y   = 3'd7
    } phase_e;

    localparam logic [2:0] PH_ALL_RED = 3'b111;

    // Internal scheduler states: the eight cycle phases keep their output code,
    // ALL_RED gets a private ninth encoding.
    localparam logic [3:0] ST_NS_GREEN  = 4'd0;
    localparam logic [3:0] ST_NS_YELLOW = 4'd1;
    localparam logic [3:0] ST_EW_LT     = 4'd2;
    localparam logic [3:0] ST_EW_LT_Y   = 4'd3;
    localparam logic [3:0] ST_EW_GREEN  = 4'd4;
    localparam logic [3:0] ST_EW_YELLOW = 4'd5;
    localparam logic [3:0] ST_NS_LT     = 4'd6;
    localparam logic [3:0] ST_NS_LT_Y   = 4'd7;
    localparam logic [3:0] ST_ALL_RED   = 4'd8;

    typedef struct packed {
        logic g;
        logic y;
        logic r;
        logic lt;
    } lamp_t;

    typedef struct packed {
        lamp_t ns;
        lamp_t ew;
    } lamps_t;

    localparam int G_T_DEF      = 40;
    localparam int Y_T_DEF      = 5;
    localparam int LT_T_DEF     = 20;
    localparam int ALLRED_T_DEF = 3;
    localparam int WALK_T_DEF   = 10;

    function automatic logic [2:0] phase_code(input logic [3:0] st);
        logic [2:0] code;
        if (st == ST_ALL_RED) begin
            code = PH_ALL_RED;
        end else begin
            code = st[2:0];
        end
        return code;
    endfunction

    // Lamp pattern for each state; anything not lit on an axis shows red.
    function automatic lamps_t lamp_decode(input logic [3:0] st);
        lamps_t l;
        l.ns = 4'b0010;
        l.ew = 4'b0010;
        case (st)
            ST_NS_GREEN:              l.ns = 4'b1000;
            ST_NS_YELLOW, ST_NS_LT_Y: l.ns = 4'b0100;
            ST_NS_LT:                 l.ns = 4'b0011;
            ST_EW_LT:                 l.ew = 4'b0011;
            ST_EW_LT_Y, ST_EW_YELLOW: l.ew = 4'b0100;
            ST_EW_GREEN:              l.ew = 4'b1000;
            default:                  l.ns = 4'b0010;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_phase_sched_phase_timer.sv
// 8-bit tick counter: counts ticks from clear and flags the tick that
// completes dur ticks, restarting itself on that tick.
module phase_timer (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick,
    input  logic [7:0] dur,
    output logic       expire
);

    logic [7:0] count_r;

    assign expire = tick && (count_r == (dur - 8'd1));

    // Tick counter, clear has priority over advance.
    always_ff @(posedge clk) begin
        if (clr) begin
            count_r <= 8'd0;
        end else if (expire) begin
            count_r <= 8'd0;
        end else if (tick) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/traffic_phase_sched.sv
// Demand-driven eight-phase intersection scheduler with pedestrian walk.
// Define TRAFFIC_LT_SKIP_EN to skip left-turn phases with no pending request.
module traffic_phase_sched
    import traffic_pkg::*;
#(
    parameter int G_T      = G_T_DEF,
    parameter int Y_T      = Y_T_DEF,
    parameter int LT_T     = LT_T_DEF,
    parameter int ALLRED_T = ALLRED_T_DEF,
    parameter int WALK_T   = WALK_T_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       lt_ns_req,
    input  logic       lt_ew_req,
    input  logic       ped_ns_req,
    input  logic       ped_ew_req,
    output logic       ns_g,
    output logic       ns_y,
    output logic       ns_r,
    output logic       ns_lt,
    output logic       ew_g,
    output logic       ew_y,
    output logic       ew_r,
    output logic       ew_lt,
    output logic       walk_ns,
    output logic       walk_ew,
    output logic [2:0] phase,
    output logic       phase_start
);

    localparam logic [7:0] G_D      = 8'(G_T);
    localparam logic [7:0] Y_D      = 8'(Y_T);
    localparam logic [7:0] LT_D     = 8'(LT_T);
    localparam logic [7:0] ALLRED_D = 8'(ALLRED_T);
    localparam logic [7:0] WALK_D   = 8'(WALK_T);

    logic [3:0] state_r;
    logic [3:0] next_state_s;
    logic [7:0] phase_dur_s;
    logic       phase_exp_s;
    logic       walk_exp_s;
    logic       walk_any_s;
    lamps_t     lamps_r;
    logic [2:0] phase_r;
    logic       phase_start_r;
    logic       walk_ns_r, walk_ew_r;
    logic       walk_ns_nx_s, walk_ew_nx_s;
    logic       lat_lt_ns_r, lat_lt_ew_r, lat_ped_ns_r, lat_ped_ew_r;
    logic       pend_lt_ns_s, pend_lt_ew_s, pend_ped_ns_s, pend_ped_ew_s;
    logic       lt_ns_go_s, lt_ew_go_s;

    assign pend_lt_ns_s  = lat_lt_ns_r  | lt_ns_req;
    assign pend_lt_ew_s  = lat_lt_ew_r  | lt_ew_req;
    assign pend_ped_ns_s = lat_ped_ns_r | ped_ns_req;
    assign pend_ped_ew_s = lat_ped_ew_r | ped_ew_req;

`ifdef TRAFFIC_LT_SKIP_EN
    assign lt_ns_go_s = pend_lt_ns_s;
    assign lt_ew_go_s = pend_lt_ew_s;
`else
    assign lt_ns_go_s = 1'b1;
    assign lt_ew_go_s = 1'b1;
`endif

    assign walk_any_s = walk_ns_r | walk_ew_r;

    phase_timer u_phase_timer (
        .clk    (clk),
        .clr    (rst),
        .tick   (tick),
        .dur    (phase_dur_s),
        .expire (phase_exp_s)
    );

    // The walk timer idles at zero whenever no walk is lit.
    phase_timer u_walk_timer (
        .clk    (clk),
        .clr    (rst | ~walk_any_s),
        .tick   (tick & walk_any_s),
        .dur    (WALK_D),
        .expire (walk_exp_s)
    );

    // Duration of the phase currently running.
    always_comb begin
        phase_dur_s = Y_D;
        case (state_r)
            ST_NS_GREEN, ST_EW_GREEN: phase_dur_s = G_D;
            ST_NS_LT, ST_EW_LT:       phase_dur_s = LT_D;
            ST_ALL_RED:               phase_dur_s = ALLRED_D;
            default:                  phase_dur_s = Y_D;
        endcase
    end

    // Phase sequencing; skip choices use the requests pending on the expiring tick.
    always_comb begin
        next_state_s = state_r;
        if (phase_exp_s) begin
            case (state_r)
                ST_ALL_RED:   next_state_s = ST_NS_GREEN;
                ST_NS_GREEN:  next_state_s = ST_NS_YELLOW;
                ST_NS_YELLOW: next_state_s = lt_ew_go_s ? ST_EW_LT : ST_EW_GREEN;
                ST_EW_LT:     next_state_s = ST_EW_LT_Y;
                ST_EW_LT_Y:   next_state_s = ST_EW_GREEN;
                ST_EW_GREEN:  next_state_s = ST_EW_YELLOW;
                ST_EW_YELLOW: next_state_s = lt_ns_go_s ? ST_NS_LT : ST_NS_GREEN;
                ST_NS_LT:     next_state_s = ST_NS_LT_Y;
                ST_NS_LT_Y:   next_state_s = ST_NS_GREEN;
                default:      next_state_s = ST_ALL_RED;
            endcase
        end else begin
            next_state_s = state_r;
        end
    end

    // Walk is granted when entering a green with its button pending and is
    // forced off by any phase change, so it never outlives its green.
    always_comb begin
        walk_ns_nx_s = walk_ns_r;
        walk_ew_nx_s = walk_ew_r;
        if (phase_exp_s) begin
            walk_ns_nx_s = (next_state_s == ST_NS_GREEN) && pend_ped_ns_s;
            walk_ew_nx_s = (next_state_s == ST_EW_GREEN) && pend_ped_ew_s;
        end else if (walk_exp_s) begin
            walk_ns_nx_s = 1'b0;
            walk_ew_nx_s = 1'b0;
        end else begin
            walk_ns_nx_s = walk_ns_r;
            walk_ew_nx_s = walk_ew_r;
        end
    end

    // State, registered lamps and request latches; a latch clear on its serving
    // phase's first cycle beats a same-cycle request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_ALL_RED;
            lamps_r       <= lamp_decode(ST_ALL_RED);
            phase_r       <= PH_ALL_RED;
            phase_start_r <= 1'b0;
            walk_ns_r     <= 1'b0;
            walk_ew_r     <= 1'b0;
            lat_lt_ns_r   <= 1'b0;
            lat_lt_ew_r   <= 1'b0;
            lat_ped_ns_r  <= 1'b0;
            lat_ped_ew_r  <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            lamps_r       <= lamp_decode(next_state_s);
            phase_r       <= phase_code(next_state_s);
            phase_start_r <= phase_exp_s;
            walk_ns_r     <= walk_ns_nx_s;
            walk_ew_r     <= walk_ew_nx_s;
            lat_lt_ns_r   <= pend_lt_ns_s  & ~(phase_start_r && (state_r == ST_NS_LT));
            lat_lt_ew_r   <= pend_lt_ew_s  & ~(phase_start_r && (state_r == ST_EW_LT));
            lat_ped_ns_r  <= pend_ped_ns_s & ~(phase_start_r && (state_r == ST_NS_GREEN));
            lat_ped_ew_r  <= pend_ped_ew_s & ~(phase_start_r && (state_r == ST_EW_GREEN));
        end
    end

    assign ns_g        = lamps_r.ns.g;
    assign ns_y        = lamps_r.ns.y;
    assign ns_r        = lamps_r.ns.r;
    assign ns_lt       = lamps_r.ns.lt;
    assign ew_g        = lamps_r.ew.g;
    assign ew_y        = lamps_r.ew.y;
    assign ew_r        = lamps_r.ew.r;
    assign ew_lt       = lamps_r.ew.lt;
    assign walk_ns     = walk_ns_r;
    assign walk_ew     = walk_ew_r;
    assign phase       = phase_r;
    assign phase_start = phase_start_r;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Randomized bench for traffic_phase_sched against a tick-countdown reference model.
module tb_traffic_phase_sched;

    localparam int G_T      = 4;
    localparam int Y_T      = 2;
    localparam int LT_T     = 3;
    localparam int ALLRED_T = 2;
    localparam int WALK_T   = 2;
    localparam int N_CYC    = 4000;

`ifdef TRAFFIC_LT_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    localparam int M_AR = 0, M_NSG = 1, M_NSY = 2, M_EWLT = 3, M_EWLTY = 4,
                   M_EWG = 5, M_EWY = 6, M_NSLT = 7, M_NSLTY = 8;

    logic       clk = 1'b0;
    logic       rst, tick, lt_ns_req, lt_ew_req, ped_ns_req, ped_ew_req;
    logic       ns_g, ns_y, ns_r, ns_lt, ew_g, ew_y, ew_r, ew_lt;
    logic       walk_ns, walk_ew, phase_start;
    logic [2:0] phase;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_now  = 0;

    int m_ph, m_rem, m_walk_left;
    bit m_walk_ns, m_start, m_rst_prev;
    bit m_lat[4];

    always #5 clk = ~clk;

    traffic_phase_sched #(
        .G_T(G_T), .Y_T(Y_T), .LT_T(LT_T), .ALLRED_T(ALLRED_T), .WALK_T(WALK_T)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .lt_ns_req(lt_ns_req), .lt_ew_req(lt_ew_req),
        .ped_ns_req(ped_ns_req), .ped_ew_req(ped_ew_req),
        .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r), .ns_lt(ns_lt),
        .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r), .ew_lt(ew_lt),
        .walk_ns(walk_ns), .walk_ew(walk_ew),
        .phase(phase), .phase_start(phase_start)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc_now, got, exp);
        end
    endtask

    // Lamps from the state table: {ns_g,ns_y,ns_r,ns_lt,ew_g,ew_y,ew_r,ew_lt}.
    function automatic logic [7:0] m_lamps(input int ph);
        case (ph)
            M_NSG:            return 8'b1000_0010;
            M_NSY, M_NSLTY:   return 8'b0100_0010;
            M_EWLT:           return 8'b0010_0011;
            M_EWLTY, M_EWY:   return 8'b0010_0100;
            M_EWG:            return 8'b0010_1000;
            M_NSLT:           return 8'b0011_0010;
            default:          return 8'b0010_0010;
        endcase
    endfunction

    function automatic logic [2:0] m_code(input int ph);
        case (ph)
            M_NSG:   return 3'd0;
            M_NSY:   return 3'd1;
            M_EWLT:  return 3'd2;
            M_EWLTY: return 3'd3;
            M_EWG:   return 3'd4;
            M_EWY:   return 3'd5;
            M_NSLT:  return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

    function automatic int m_dur(input int ph);
        case (ph)
            M_AR:          return ALLRED_T;
            M_NSG, M_EWG:  return G_T;
            M_NSLT, M_EWLT: return LT_T;
            default:       return Y_T;
        endcase
    endfunction

    function automatic int m_next(input int ph, input bit lt_ns, input bit lt_ew);
        case (ph)
            M_AR:    return M_NSG;
            M_NSG:   return M_NSY;
            M_NSY:   return (SKIP && !lt_ew) ? M_EWG : M_EWLT;
            M_EWLT:  return M_EWLTY;
            M_EWLTY: return M_EWG;
            M_EWG:   return M_EWY;
            M_EWY:   return (SKIP && !lt_ns) ? M_NSG : M_NSLT;
            M_NSLT:  return M_NSLTY;
            default: return M_NSG;
        endcase
    endfunction

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_step();
        bit p[4];
        int nxt;
        m_rst_prev = rst;
        if (rst) begin
            m_ph = M_AR; m_rem = ALLRED_T; m_walk_left = 0; m_start = 1'b0;
            for (int i = 0; i < 4; i++) m_lat[i] = 1'b0;
            return;
        end
        p[0] = m_lat[0] | lt_ns_req;
        p[1] = m_lat[1] | lt_ew_req;
        p[2] = m_lat[2] | ped_ns_req;
        p[3] = m_lat[3] | ped_ew_req;
        for (int i = 0; i < 4; i++) m_lat[i] = p[i];
        if (m_start) begin
            case (m_ph)
                M_NSLT:  m_lat[0] = 1'b0;
                M_EWLT:  m_lat[1] = 1'b0;
                M_NSG:   m_lat[2] = 1'b0;
                M_EWG:   m_lat[3] = 1'b0;
                default: ;
            endcase
        end
        m_start = 1'b0;
        if (tick) begin
            if (m_walk_left > 0) m_walk_left--;
            m_rem--;
            if (m_rem == 0) begin
                nxt = m_next(m_ph, p[0], p[1]);
                m_ph = nxt;
                m_rem = m_dur(nxt);
                m_start = 1'b1;
                m_walk_left = 0;
                if (nxt == M_NSG && p[2]) begin m_walk_left = WALK_T; m_walk_ns = 1'b1; end
                if (nxt == M_EWG && p[3]) begin m_walk_left = WALK_T; m_walk_ns = 1'b0; end
            end
        end
    endtask

    initial begin
        rst = 1'b1; tick = 1'b1;
        lt_ns_req = 1'b0; lt_ew_req = 1'b0; ped_ns_req = 1'b0; ped_ew_req = 1'b0;
        m_walk_ns = 1'b0; m_rst_prev = 1'b1;
        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(negedge clk);
            cyc_now = cyc;
            if (cyc > 0) begin
                check("lamps", 32'({ns_g, ns_y, ns_r, ns_lt, ew_g, ew_y, ew_r, ew_lt}),
                      32'(m_lamps(m_ph)));
                check("phase", 32'(phase), 32'(m_code(m_ph)));
                check("phase_start", 32'(phase_start), 32'(m_start));
                check("walk", 32'({walk_ns, walk_ew}),
                      32'({(m_walk_left > 0) && m_walk_ns, (m_walk_left > 0) && !m_walk_ns}));
                check("no_conflict", 32'((ns_g | ns_lt) & (ew_g | ew_lt)), 32'd0);
                if (m_rst_prev) begin
                    check("reset_lamps", 32'({ns_g, ns_y, ns_r, ns_lt, ew_g, ew_y, ew_r, ew_lt}),
                          32'h22);
                    check("reset_phase", 32'(phase), 32'h7);
                    check("reset_walk_start", 32'({walk_ns, walk_ew, phase_start}), 32'h0);
                end
            end
            if (cyc < 3) begin
                rst = 1'b1;
            end else begin
                rst = ($urandom_range(0, 399) == 0);
            end
            if (cyc >= 500 && cyc < 510) begin
                tick = 1'b0;
            end else begin
                tick = ($urandom_range(0, 99) < 85);
            end
            lt_ns_req  = ($urandom_range(0, 99) < 4);
            lt_ew_req  = ($urandom_range(0, 99) < 4);
            ped_ns_req = ($urandom_range(0, 99) < 5);
            ped_ew_req = ($urandom_range(0, 99) < 5);
            model_step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
